// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: Wishbone master microsequencer that runs an op program
// from a synchronous ROM to bring up the sdc_controller register file.
module sd_init_sequencer #(
    parameter int PC_W        = 6,
    parameter int ACK_TIMEOUT = 255,
    parameter int POLL_LIMIT  = 4095,
    parameter int START_PC    = 0
) (
    input  logic            wb_clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code,
    output logic [PC_W-1:0] err_pc,
    output logic [PC_W-1:0] prog_addr,
    input  logic [42:0]     prog_data,
    output logic [31:0]     last_rd,
    output logic [7:0]      wb_adr_o,
    output logic [31:0]     wb_dat_o,
    input  logic [31:0]     wb_dat_i,
    output logic [3:0]      wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i
);

    localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
    localparam int PL_W = $clog2(POLL_LIMIT + 1);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_POLL  = 3'd3;
    localparam logic [2:0] OP_JUMP  = 3'd4;
    localparam logic [2:0] OP_HALT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_BUS,
        S_CHECK,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [PC_W-1:0] err_pc_q, err_pc_d;
    logic [31:0]     last_rd_q, last_rd_d;
    logic [7:0]      adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic [2:0]      op_q, op_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [PL_W-1:0] poll_q, poll_d;

    logic            fault;
    logic [1:0]      fault_code;
    logic [2:0]      opc;

    assign opc = prog_data[42:40];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        err_pc_d   = err_pc_q;
        last_rd_d  = last_rd_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        op_d       = op_q;
        wdog_d     = wdog_q;
        poll_d     = poll_q;
        fault      = 1'b0;
        fault_code = 2'b00;

        case (state_q)
            S_IDLE, S_HALTED, S_FAULT: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'b00;
                    pc_d       = PC_W'(START_PC);
                    busy_d     = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d = opc;
                case (opc)
                    OP_NOP: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                    OP_WRITE, OP_READ, OP_POLL: begin
                        adr_d   = prog_data[39:32];
                        dat_d   = prog_data[31:0];
                        we_d    = (opc == OP_WRITE);
                        cyc_d   = 1'b1;
                        wdog_d  = '0;
                        poll_d  = '0;
                        state_d = S_BUS;
                    end
                    OP_JUMP: begin
                        pc_d    = prog_data[PC_W-1:0];
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_HALTED;
                    end
                    default: begin
                        fault      = 1'b1;
                        fault_code = 2'b11;
                    end
                endcase
            end
            S_BUS: begin
                // ack is checked first so it beats a watchdog expiring on the same edge
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    if (!we_q) begin
                        last_rd_d = wb_dat_i;
                    end
                    if (op_q == OP_POLL) begin
                        state_d = S_CHECK;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                end else if (wdog_q == WD_W'(ACK_TIMEOUT - 1)) begin
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    fault      = 1'b1;
                    fault_code = 2'b01;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_CHECK: begin
                if ((last_rd_q & dat_q) != 32'd0) begin
                    poll_d  = '0;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end else if (poll_q == PL_W'(POLL_LIMIT)) begin
                    fault      = 1'b1;
                    fault_code = 2'b10;
                end else begin
                    poll_d  = poll_q + PL_W'(1);
                    cyc_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = S_BUS;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fault) begin
            state_d    = S_FAULT;
            error_d    = 1'b1;
            err_code_d = fault_code;
            err_pc_d   = pc_q;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_W'(START_PC);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
            err_pc_q   <= '0;
            last_rd_q  <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            op_q       <= '0;
            wdog_q     <= '0;
            poll_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            last_rd_q  <= last_rd_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            op_q       <= op_d;
            wdog_q     <= wdog_d;
            poll_q     <= poll_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign err_pc    = err_pc_q;
    assign prog_addr = pc_q;
    assign last_rd   = last_rd_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = 4'b1111;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;

endmodule

// File: doc/sd_init_sequencer.md
Name: sd_init_sequencer

Overview:
- Parametrised Wishbone-master microsequencer that brings up and drives the sdc_controller register file.
- It executes an op program fetched from an external program memory, which makes the op list depth and contents generic.
- Beyond plain register writes and reads, it supports polling a register against a mask with a timeout, jumps, halt, a per-access ack watchdog, and error reporting.
- Sits between the top-level control (start/status/LEDs) and the sdc_controller slave port.

Parameters:
- PC_W, 6, program counter width; program depth is 2**PC_W ops.
- ACK_TIMEOUT, 255, wb_clk cycles allowed between stb assertion and ack before an error is raised.
- POLL_LIMIT, 4095, maximum POLL re-reads before an error is raised.
- START_PC, 0, program address loaded on start.

Ports:
- wb_clk  in  1  system/Wishbone clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse; begins execution at START_PC
- busy  out  1  high while executing
- done  out  1  high after a HALT op; cleared on start
- error  out  1  sticky error flag; cleared on start
- err_code  out  2  01 ack timeout, 10 poll timeout, 11 illegal opcode
- err_pc  out  PC_W  PC of the op that faulted
- prog_addr  out  PC_W  program memory address
- prog_data  in  43  op word; valid 1 cycle after prog_addr (synchronous ROM)
- last_rd  out  32  data captured by the last READ/POLL
- wb_adr_o  out  8  register address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  always 4'b1111
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  slave ack

Behaviour:
- Reset (async, wb_clk domain):
  - State IDLE; pc=START_PC.
  - busy, done, error, cyc, stb, we = 0; err_code=0, err_pc=0, last_rd=0, wb_adr_o=0, wb_dat_o=0.
- Op word layout:
  - [42:40] opcode; [39:32] reg addr; [31:0] value.
  - value is the write data, the POLL mask, or the JUMP target in [PC_W-1:0].
- Opcodes: 0 NOP, 1 WRITE, 2 READ, 3 POLL, 4 JUMP, 5 HALT; 6 and 7 are illegal.
- All Wishbone outputs are registered.
- States: IDLE, FETCH, DECODE, BUS, CHECK, HALTED, FAULT.
- IDLE:
  - start -> clear done/error/err_code, pc=START_PC, busy=1, go to FETCH.
  - start is ignored in any other state except HALTED and FAULT, which behave like IDLE on start.
- FETCH: prog_addr=pc; go to DECODE the next cycle, where prog_data is valid.
- DECODE:
  - NOP: pc+1, go to FETCH.
  - WRITE/READ/POLL: on the next edge, drive adr/dat, we=(op==WRITE), cyc=stb=1, reset watchdog, go to BUS.
  - JUMP: pc=target, go to FETCH.
  - HALT: done=1, busy=0, go to HALTED.
  - Illegal: go to FAULT with code 11.
- BUS:
  - Hold cyc/stb/adr/dat stable until wb_ack_i is sampled high.
  - On that edge, cyc=stb=we=0. For reads, latch wb_dat_i into last_rd.
  - WRITE/READ then pc+1 and go to FETCH; POLL goes to CHECK.
  - Watchdog counts cycles in BUS. When it reaches ACK_TIMEOUT without ack: drop cyc/stb, go to FAULT with code 01.
- CHECK:
  - (last_rd & mask) != 0 -> clear poll counter, pc+1, go to FETCH.
  - Otherwise, if poll counter == POLL_LIMIT -> go to FAULT with code 10.
  - Otherwise increment the counter and reissue the same read (back to BUS on the next edge, min 1 idle cycle between cycles).
- FAULT: error=1, err_pc=pc, busy=0.
- pc arithmetic: modulo 2**PC_W, so incrementing from the last op wraps to 0.
- A JUMP to itself loops forever with busy=1; this is legal and there is no watchdog on it.
- Ack arriving outside BUS is ignored.
- Ack in the same cycle the watchdog expires: the ack wins and the access completes normally.
- Reset mid-cycle: cyc/stb drop asynchronously; no further ack is processed.
- Throughput: WRITE/READ op = 3 cycles + ack latency; NOP = 2 cycles; JUMP = 2 cycles.

Test Plan:
- Program {WRITE 0x24←0x3, READ 0x24, HALT}, slave acks after 1 cycle, then start:
  - exactly one write cycle with adr=0x24, dat=0x3, we=1, followed by a read cycle;
  - last_rd=0x3; done=1, busy=0, error=0.
- POLL 0x34 mask 0x1; slave returns 0 three times, then 0x1:
  - exactly 4 read cycles;
  - pc advances, and the next op executes.
- POLL that never matches, POLL_LIMIT=4: 5 reads, then error=1, err_code=10, err_pc = POLL address.
- Slave never acks, ACK_TIMEOUT=8:
  - cyc drops 8 cycles after stb;
  - err_code=01, busy=0.
- Opcode 7 at pc=2 -> err_code=11, err_pc=2, no bus cycle issued.
- Other cases:
  - JUMP to 0 from the last address with PC_W=2 wraps correctly;
  - start while busy is ignored;
  - asserting reset while stb=1 clears cyc/stb immediately;
  - a new start after FAULT clears error and reruns the program.
